// File: rtl/conv_tile_scheduler.sv
// Tile sequencer for the single-PE 3x3 conv engine: walks an FMAP_W map as 4x4 tiles at stride 2.
// Optional build macro CONV_RELU_EN clamps negative results to zero on the write path.

module conv_res_lane (
  input  logic       clk,
  input  logic       rst,
  input  logic       cap,
  input  logic [7:0] d,
  output logic [7:0] q
);
  logic [7:0] r;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)     r <= '0;
    else if (cap) r <= d;
  end

`ifdef CONV_RELU_EN
  assign q = r[7] ? 8'h00 : r;
`else
  assign q = r;
`endif
endmodule

module conv_tile_scheduler #(
  parameter  int FMAP_W = 8,
  localparam int OUT_W  = FMAP_W - 2,
  localparam int NT     = FMAP_W / 2 - 1,
  localparam int RW     = $clog2(FMAP_W),
  localparam int AW     = $clog2(OUT_W * OUT_W)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic          tile_req,
  output logic [RW-1:0] tile_row,
  output logic [RW-1:0] tile_col,
  input  logic          tile_ack,
  output logic          eng_active,
  input  logic          eng_done,
  input  logic [7:0]    eng_c11,
  input  logic [7:0]    eng_c12,
  input  logic [7:0]    eng_c21,
  input  logic [7:0]    eng_c22,
  output logic          wr_en,
  output logic [AW-1:0] wr_addr,
  output logic [7:0]    wr_data
);
  localparam int NUM_LANES = 4;
  localparam logic [RW-1:0] TLAST = RW'(NT - 1);

  typedef enum logic [2:0] {S_IDLE, S_REQ, S_RUN, S_WR, S_NEXT, S_DONE} state_t;

  state_t        state, state_d;
  logic [RW-1:0] tr, tc;
  logic [1:0]    wi;
  logic [AW-1:0] base_q;
  logic [AW-1:0] off;
  logic          cap;

  logic [NUM_LANES-1:0][7:0] eng_c;
  logic [NUM_LANES-1:0][7:0] lane_q;

  assign eng_c = {eng_c22, eng_c21, eng_c12, eng_c11};
  assign cap   = (state == S_RUN) && eng_done;

  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    conv_res_lane u_lane (
      .clk (clk),
      .rst (rst),
      .cap (cap),
      .d   (eng_c[l]),
      .q   (lane_q[l])
    );
  end

  always_comb begin
    state_d = state;
    case (state)
      S_IDLE: if (start)    state_d = S_REQ;
      S_REQ:  if (tile_ack) state_d = S_RUN;
      S_RUN:  if (eng_done) state_d = S_WR;
      S_WR:   if (wi == 2'd3) state_d = S_NEXT;
      S_NEXT: state_d = (tc == TLAST && tr == TLAST) ? S_DONE : S_REQ;
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // base_q tracks the top-left output address of the current tile so no multiply is needed
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= S_IDLE;
      tr     <= '0;
      tc     <= '0;
      wi     <= '0;
      base_q <= '0;
    end else begin
      state <= state_d;
      case (state)
        S_IDLE: if (start) begin
          tr     <= '0;
          tc     <= '0;
          base_q <= '0;
        end
        S_RUN: wi <= '0;
        S_WR:  wi <= wi + 2'd1;
        S_NEXT: begin
          if (tc != TLAST) begin
            tc     <= tc + 1'b1;
            base_q <= base_q + AW'(2);
          end else if (tr != TLAST) begin
            tc     <= '0;
            tr     <= tr + 1'b1;
            base_q <= base_q + AW'(OUT_W + 2);
          end
        end
        S_DONE: begin
          tr     <= '0;
          tc     <= '0;
          base_q <= '0;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    off = '0;
    case (wi)
      2'd0: off = '0;
      2'd1: off = AW'(1);
      2'd2: off = AW'(OUT_W);
      2'd3: off = AW'(OUT_W + 1);
      default: off = '0;
    endcase
  end

  assign busy       = (state != S_IDLE);
  assign done       = (state == S_DONE);
  assign tile_req   = (state == S_REQ);
  assign eng_active = (state == S_RUN);
  assign wr_en      = (state == S_WR);
  assign tile_row   = tr << 1;
  assign tile_col   = tc << 1;
  assign wr_addr    = wr_en ? base_q + off : '0;
  assign wr_data    = wr_en ? lane_q[wi] : '0;
endmodule
